// File: rtl/wb_arbiter_rr_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | wb_arbiter_rr_if : flattened multi-master / single-slave Wishbone B3     |
// | bundle; "slave" is the arbiter's view, "master" the surroundings. Rev 1.0|
// +--------------------------------------------------------------------------+
interface wb_arbiter_rr_if #(
  parameter int MASTERS    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  localparam int SEL_WIDTH = DATA_WIDTH >> 3;

  logic [ADDR_WIDTH*MASTERS-1:0] m_adr_i;
  logic [DATA_WIDTH*MASTERS-1:0] m_dat_i;
  logic [MASTERS-1:0]            m_cyc_i;
  logic [MASTERS-1:0]            m_stb_i;
  logic [MASTERS-1:0]            m_we_i;
  logic [SEL_WIDTH*MASTERS-1:0]  m_sel_i;
  logic [3*MASTERS-1:0]          m_cti_i;
  logic [2*MASTERS-1:0]          m_bte_i;
  logic [DATA_WIDTH*MASTERS-1:0] m_dat_o;
  logic [MASTERS-1:0]            m_ack_o;
  logic [MASTERS-1:0]            m_err_o;
  logic [MASTERS-1:0]            m_rty_o;

  logic [ADDR_WIDTH-1:0]         s_adr_o;
  logic [DATA_WIDTH-1:0]         s_dat_o;
  logic                          s_cyc_o;
  logic                          s_stb_o;
  logic                          s_we_o;
  logic [SEL_WIDTH-1:0]          s_sel_o;
  logic [2:0]                    s_cti_o;
  logic [1:0]                    s_bte_o;
  logic [DATA_WIDTH-1:0]         s_dat_i;
  logic                          s_ack_i;
  logic                          s_err_i;
  logic                          s_rty_i;

  modport slave (
    input  m_adr_i, m_dat_i, m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_cti_i, m_bte_i,
    input  s_dat_i, s_ack_i, s_err_i, s_rty_i,
    output m_dat_o, m_ack_o, m_err_o, m_rty_o,
    output s_adr_o, s_dat_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_cti_o, s_bte_o
  );

  modport master (
    output m_adr_i, m_dat_i, m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_cti_i, m_bte_i,
    output s_dat_i, s_ack_i, s_err_i, s_rty_i,
    input  m_dat_o, m_ack_o, m_err_o, m_rty_o,
    input  s_adr_o, s_dat_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_cti_o, s_bte_o
  );
endinterface
`default_nettype wire

// File: rtl/wb_arbiter_rr.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | wb_arbiter_rr : round-robin Wishbone B3 arbiter, grant held until cyc    |
// | drops; define WB_ARB_TIMEOUT_EN for the stall watchdog.       Rev 1.0    |
// +--------------------------------------------------------------------------+
module wb_arbiter_rr #(
  parameter int MASTERS        = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               clk_i,
  input  logic               rst_i,
  wb_arbiter_rr_if.slave     bus,
  output logic [MASTERS-1:0] grant_o,
  output logic               timeout_o
);
  localparam int SEL_WIDTH = DATA_WIDTH >> 3;
  localparam int IDX_W     = (MASTERS > 1) ? $clog2(MASTERS) : 1;
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(MASTERS - 1);

  if (MASTERS < 1 || MASTERS > 16 || (DATA_WIDTH % 8) != 0 ||
      TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
    $error("wb_arbiter_rr: illegal parameter value");
  end

  logic             gnt_valid_q, gnt_valid_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic             w_active;
  logic             w_found;
  logic [IDX_W-1:0] w_pick;
  logic [IDX_W-1:0] w_idx;
  logic             w_expire;

  assign w_active = gnt_valid_q & bus.m_cyc_i[owner_q];

  // Walk downward so the requester nearest to last+1 is the one left in w_pick.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = '0;
    for (int k = MASTERS; k >= 1; k--) begin
      w_idx = IDX_W'((int'(last_q) + k) % MASTERS);
      if (bus.m_cyc_i[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  always_comb begin
    gnt_valid_d = gnt_valid_q;
    owner_d     = owner_q;
    last_d      = last_q;
    if (!w_active) begin
      gnt_valid_d = w_found;
      if (w_found) begin
        owner_d = w_pick;
        last_d  = w_pick;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      gnt_valid_q <= 1'b0;
      owner_q     <= '0;
      last_q      <= LAST_RST;
    end else begin
      gnt_valid_q <= gnt_valid_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  logic [15:0] tmo_cnt_q, tmo_cnt_d;
  logic        w_resp;
  logic        w_stall;

  assign w_resp   = bus.s_ack_i | bus.s_err_i | bus.s_rty_i;
  assign w_stall  = w_active & bus.m_stb_i[owner_q] & ~w_resp;
  // Fires on the TIMEOUT_CYCLES-th consecutive stalled strobe.
  assign w_expire = w_stall & (tmo_cnt_q == 16'(TIMEOUT_CYCLES - 1));

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (!w_active || w_resp || w_expire) begin
      tmo_cnt_d = '0;
    end else if (w_stall) begin
      tmo_cnt_d = tmo_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  assign w_expire = 1'b0;
`endif

  assign timeout_o   = w_expire;
  assign bus.m_dat_o = {MASTERS{bus.s_dat_i}};

  always_comb begin
    bus.s_cyc_o = 1'b0;
    bus.s_stb_o = 1'b0;
    bus.s_adr_o = '0;
    bus.s_dat_o = '0;
    bus.s_we_o  = 1'b0;
    bus.s_sel_o = '0;
    bus.s_cti_o = '0;
    bus.s_bte_o = '0;
    bus.m_ack_o = '0;
    bus.m_err_o = '0;
    bus.m_rty_o = '0;
    grant_o     = '0;
    if (w_active) begin
      bus.s_cyc_o          = 1'b1;
      bus.s_stb_o          = bus.m_stb_i[owner_q] & ~w_expire;
      bus.s_adr_o          = bus.m_adr_i[int'(owner_q)*ADDR_WIDTH +: ADDR_WIDTH];
      bus.s_dat_o          = bus.m_dat_i[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH];
      bus.s_we_o           = bus.m_we_i[owner_q];
      bus.s_sel_o          = bus.m_sel_i[int'(owner_q)*SEL_WIDTH +: SEL_WIDTH];
      bus.s_cti_o          = bus.m_cti_i[int'(owner_q)*3 +: 3];
      bus.s_bte_o          = bus.m_bte_i[int'(owner_q)*2 +: 2];
      bus.m_ack_o[owner_q] = bus.s_ack_i;
      bus.m_err_o[owner_q] = bus.s_err_i | w_expire;
      bus.m_rty_o[owner_q] = bus.s_rty_i;
      grant_o[owner_q]     = 1'b1;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter_rr.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_wb_arbiter_rr : vector table, corner sequences and random traffic     |
// | against a rotation-distance reference model.                  Rev 1.0    |
// +--------------------------------------------------------------------------+
module tb_wb_arbiter_rr;
  localparam int M   = 4;
  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int SW  = DW >> 3;
  localparam int TMO = 8;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b0;
  logic [M-1:0] grant_o;
  logic         timeout_o;
  int           errors = 0;
  int           checks = 0;

  wb_arbiter_rr_if #(.MASTERS(M), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  wb_arbiter_rr #(
    .MASTERS(M), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .bus(bus), .grant_o(grant_o), .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  logic [M-1:0]    cyc, stb, we;
  logic [AW-1:0]   adr [M];
  logic [DW-1:0]   dat [M];
  logic [SW-1:0]   sel [M];
  logic [2:0]      cti [M];
  logic [1:0]      bte [M];
  logic            sack, serr, srty;
  logic [DW-1:0]   sdat;

  typedef struct {
    logic         rst_n;
    logic [M-1:0] cyc;
    logic         ack;
    logic [M-1:0] exp_gnt;
    logic [M-1:0] exp_ack;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input logic r, input logic [M-1:0] c, input logic a,
                     input logic [M-1:0] g, input logic [M-1:0] k);
    vec_t v;
    v.rst_n = r; v.cyc = c; v.ack = a; v.exp_gnt = g; v.exp_ack = k;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < M; i++) begin
      bus.m_adr_i[i*AW +: AW] = adr[i];
      bus.m_dat_i[i*DW +: DW] = dat[i];
      bus.m_sel_i[i*SW +: SW] = sel[i];
      bus.m_cti_i[i*3 +: 3]   = cti[i];
      bus.m_bte_i[i*2 +: 2]   = bte[i];
    end
    bus.m_cyc_i = cyc;
    bus.m_stb_i = stb;
    bus.m_we_i  = we;
    bus.s_ack_i = sack;
    bus.s_err_i = serr;
    bus.s_rty_i = srty;
    bus.s_dat_i = sdat;
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [AW-1:0] fixed_adr(input int i);
    return 32'h8000_0000 | AW'(i << 3);
  endfunction

  function automatic logic [AW-1:0] adr_for_grant(input logic [M-1:0] g);
    for (int i = 0; i < M; i++) if (g[i]) return fixed_adr(i);
    return '0;
  endfunction

  task automatic set_defaults();
    for (int i = 0; i < M; i++) begin
      adr[i] = fixed_adr(i);
      dat[i] = 32'hD000_0000 + DW'(i);
      sel[i] = '1;
      cti[i] = 3'b000;
      bte[i] = 2'b00;
    end
    we = 4'b1010; cyc = '0; stb = '0;
    sack = 1'b0; serr = 1'b0; srty = 1'b0; sdat = 32'h1234_5678;
  endtask

  // Reference model state: owner (-1 = none), last granted index, stall count.
  int mown, mlast, mstall;

  task automatic model_cycle_check(input int n);
    bit active, stalled, expire, resp;
    logic [M-1:0] g;
    active  = (mown >= 0) && cyc[mown];
    resp    = sack | serr | srty;
    stalled = active && stb[mown] && !resp;
`ifdef WB_ARB_TIMEOUT_EN
    expire  = stalled && (mstall + 1 == TMO);
`else
    expire  = 1'b0;
`endif
    g = active ? M'(1 << mown) : '0;
    chk($sformatf("rnd%0d grant", n), grant_o, g);
    chk($sformatf("rnd%0d s_cyc", n), bus.s_cyc_o, active);
    chk($sformatf("rnd%0d s_stb", n), bus.s_stb_o, active && stb[mown] && !expire);
    chk($sformatf("rnd%0d s_adr", n), bus.s_adr_o, active ? adr[mown] : '0);
    chk($sformatf("rnd%0d s_dat", n), bus.s_dat_o, active ? dat[mown] : '0);
    chk($sformatf("rnd%0d s_we", n), bus.s_we_o, active ? we[mown] : 1'b0);
    chk($sformatf("rnd%0d s_sel", n), bus.s_sel_o, active ? sel[mown] : '0);
    chk($sformatf("rnd%0d s_cti", n), {bus.s_bte_o, bus.s_cti_o},
        active ? {bte[mown], cti[mown]} : 5'd0);
    chk($sformatf("rnd%0d m_ack", n), bus.m_ack_o, sack ? g : '0);
    chk($sformatf("rnd%0d m_err", n), bus.m_err_o, (serr || expire) ? g : '0);
    chk($sformatf("rnd%0d m_rty", n), bus.m_rty_o, srty ? g : '0);
    chk($sformatf("rnd%0d timeout", n), timeout_o, expire);
    chk($sformatf("rnd%0d m_dat", n), bus.m_dat_o, {M{sdat}});
    // Advance model to the next edge.
    if (!active || resp || expire) mstall = 0;
    else if (stalled) mstall++;
    if (!active) begin
      int best, bestd;
      best = -1; bestd = M;
      for (int i = 0; i < M; i++) begin
        int d;
        d = (i - mlast - 1 + 2*M) % M;
        if (cyc[i] && d < bestd) begin best = i; bestd = d; end
      end
      mown = best;
      if (best >= 0) mlast = best;
    end
  endtask

  logic [2:0] beats [4];

  initial begin
    set_defaults();
    cyc = '1; stb = '1;
    drive();
    next_cycle(); next_cycle();
    #4;
    chk("reset grant", grant_o, '0);
    chk("reset s_cyc", bus.s_cyc_o, 1'b0);
    chk("reset s_stb", bus.s_stb_o, 1'b0);
    chk("reset s_adr", bus.s_adr_o, '0);
    chk("reset timeout", timeout_o, 1'b0);
    next_cycle();

    // rst, cyc, ack, expected grant, expected m_ack
    add(1, 4'b0100, 0, 4'b0000, 4'b0000);
    add(1, 4'b0100, 1, 4'b0100, 4'b0100);
    add(1, 4'b0000, 1, 4'b0000, 4'b0000);
    add(0, 4'b0000, 0, 4'b0000, 4'b0000);
    add(1, 4'b1001, 0, 4'b0000, 4'b0000);
    add(1, 4'b1001, 1, 4'b0001, 4'b0001);
    add(1, 4'b1000, 0, 4'b0000, 4'b0000);
    add(1, 4'b1000, 1, 4'b1000, 4'b1000);
    add(1, 4'b0000, 0, 4'b0000, 4'b0000);
    add(1, 4'b1111, 0, 4'b0000, 4'b0000);
    add(1, 4'b1111, 1, 4'b0001, 4'b0001);
    add(1, 4'b1110, 0, 4'b0000, 4'b0000);
    add(1, 4'b1111, 1, 4'b0010, 4'b0010);
    add(1, 4'b1101, 0, 4'b0000, 4'b0000);
    add(1, 4'b1111, 1, 4'b0100, 4'b0100);
    add(1, 4'b1011, 0, 4'b0000, 4'b0000);
    add(1, 4'b1111, 1, 4'b1000, 4'b1000);
    add(1, 4'b0111, 0, 4'b0000, 4'b0000);
    add(1, 4'b1111, 1, 4'b0001, 4'b0001);
    add(1, 4'b1110, 0, 4'b0000, 4'b0000);
    add(1, 4'b1111, 1, 4'b0010, 4'b0010);
    add(1, 4'b0000, 0, 4'b0000, 4'b0000);

    foreach (vecs[n]) begin
      rst_i = vecs[n].rst_n; cyc = vecs[n].cyc; stb = vecs[n].cyc; sack = vecs[n].ack;
      drive();
      #4;
      chk($sformatf("vec%0d grant", n), grant_o, vecs[n].exp_gnt);
      chk($sformatf("vec%0d m_ack", n), bus.m_ack_o, vecs[n].exp_ack);
      chk($sformatf("vec%0d s_cyc", n), bus.s_cyc_o, |vecs[n].exp_gnt);
      chk($sformatf("vec%0d s_adr", n), bus.s_adr_o, adr_for_grant(vecs[n].exp_gnt));
      next_cycle();
    end

    // Master 1 burst holds the bus while master 0 waits.
    beats[0] = 3'b010; beats[1] = 3'b010; beats[2] = 3'b010; beats[3] = 3'b111;
    cyc = 4'b0010; stb = 4'b0010; cti[1] = 3'b010; sack = 1'b0; drive(); #4;
    chk("burst latency grant", grant_o, 4'b0000);
    next_cycle();
    for (int b = 0; b < 4; b++) begin
      cyc = 4'b0011; stb = 4'b0011; cti[1] = beats[b]; sack = 1'b1; drive(); #4;
      chk($sformatf("burst%0d grant", b), grant_o, 4'b0010);
      chk($sformatf("burst%0d m_ack", b), bus.m_ack_o, 4'b0010);
      chk($sformatf("burst%0d s_cti", b), bus.s_cti_o, beats[b]);
      next_cycle();
    end
    cyc = 4'b0001; stb = 4'b0001; cti[1] = 3'b000; sack = 1'b0; drive(); #4;
    chk("burst handover grant", grant_o, 4'b0000);
    chk("burst handover s_cyc", bus.s_cyc_o, 1'b0);
    next_cycle();
    sack = 1'b1; drive(); #4;
    chk("after burst grant", grant_o, 4'b0001);
    chk("after burst m_ack", bus.m_ack_o, 4'b0001);
    next_cycle();
    cyc = '0; stb = '0; sack = 1'b0; drive(); next_cycle();

    // Reset in the middle of master 1's burst.
    cyc = 4'b0011; stb = 4'b0011; cti[1] = 3'b010; drive(); next_cycle();
    sack = 1'b1; drive(); #4;
    chk("midrst pre grant", grant_o, 4'b0010);
    next_cycle();
    rst_i = 1'b0; drive(); #4;
    chk("midrst edge-1 grant", grant_o, 4'b0010);
    next_cycle();
    #4;
    chk("midrst grant", grant_o, 4'b0000);
    chk("midrst s_cyc", bus.s_cyc_o, 1'b0);
    chk("midrst m_ack", bus.m_ack_o, 4'b0000);
    next_cycle();
    rst_i = 1'b1; sack = 1'b0; cti[1] = 3'b000; drive(); next_cycle();
    #4;
    chk("post rst winner", grant_o, 4'b0001);
    next_cycle();
    cyc = '0; stb = '0; drive(); next_cycle();

    // Hung slave: master 2 strobes with no response.
    cyc = 4'b0100; stb = 4'b0100; drive(); next_cycle();
    for (int s = 1; s <= 12; s++) begin
      bit exp_to;
`ifdef WB_ARB_TIMEOUT_EN
      exp_to = (s == TMO);
`else
      exp_to = 1'b0;
`endif
      #4;
      chk($sformatf("stall%0d grant", s), grant_o, 4'b0100);
      chk($sformatf("stall%0d s_stb", s), bus.s_stb_o, !exp_to);
      chk($sformatf("stall%0d m_err", s), bus.m_err_o, exp_to ? 4'b0100 : 4'b0000);
      chk($sformatf("stall%0d timeout", s), timeout_o, exp_to);
      next_cycle();
    end
    cyc = '0; stb = '0; drive(); next_cycle();

    // Random traffic against the reference model, starting from reset.
    rst_i = 1'b0; drive(); next_cycle();
    rst_i = 1'b1;
    mown = -1; mlast = M - 1; mstall = 0;
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < M; i++) begin
        if (cyc[i]) begin
          if ($urandom_range(3) == 0) cyc[i] = 1'b0;
        end else if ($urandom_range(2) == 0) begin
          cyc[i] = 1'b1;
        end
        stb[i] = cyc[i] & ($urandom_range(3) != 0);
        adr[i] = $urandom; dat[i] = $urandom; we[i] = 1'($urandom);
        sel[i] = SW'($urandom); cti[i] = 3'($urandom); bte[i] = 2'($urandom);
      end
      sack = ($urandom_range(2) == 0);
      serr = ($urandom_range(7) == 0);
      srty = ($urandom_range(7) == 0);
      sdat = $urandom;
      drive();
      #4;
      model_cycle_check(n);
      next_cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/wb_arbiter_rr.md
Name: wb_arbiter_rr

Overview:
- Round-robin arbiter that shares one Wishbone B3 slave-side bus (the input of the address decoder) among MASTERS bus masters.
- Grants the bus to one master per bus cycle and holds the grant for the whole cycle, including B3 bursts, until that master drops cyc.
- Routes the owner's request signals to the bus and its responses back to that master only.
- Ports are flattened: master s occupies slice [(s+1)*W-1 : s*W] of each vector.

Parameters:
- MASTERS, 4, number of masters (1..16).
- DATA_WIDTH, 32, data width in bits; must be a multiple of 8.
- ADDR_WIDTH, 32, address width in bits.
- SEL_WIDTH, DATA_WIDTH>>3, localparam: byte-select width.
- TIMEOUT_CYCLES, 255, watchdog limit in cycles (1..65535); used only with WB_ARB_TIMEOUT_EN.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-low.
- m_adr_i  in  ADDR_WIDTH*MASTERS  master addresses.
- m_dat_i  in  DATA_WIDTH*MASTERS  master write data.
- m_cyc_i, m_stb_i, m_we_i  in  MASTERS each  master cycle / strobe / write enable.
- m_sel_i  in  SEL_WIDTH*MASTERS  master byte selects.
- m_cti_i  in  3*MASTERS  cycle type identifier.
- m_bte_i  in  2*MASTERS  burst type extension.
- m_dat_o  out  DATA_WIDTH*MASTERS  read data to masters.
- m_ack_o, m_err_o, m_rty_o  out  MASTERS each  responses to masters.
- s_adr_o  out  ADDR_WIDTH  bus address.
- s_dat_o  out  DATA_WIDTH  bus write data.
- s_cyc_o, s_stb_o, s_we_o  out  1 each  bus cycle / strobe / write enable.
- s_sel_o  out  SEL_WIDTH  bus byte selects.
- s_cti_o  out  3  bus cycle type.
- s_bte_o  out  2  bus burst type.
- s_dat_i  in  DATA_WIDTH  bus read data.
- s_ack_i, s_err_i, s_rty_i  in  1 each  bus responses.
- grant_o  out  MASTERS  one-hot current grant; all zero when idle.
- timeout_o  out  1  one-cycle pulse on watchdog expiry; constant 0 without the macro.

Behaviour:
- State registers: gnt_valid (1 bit), owner and last (each clog2(MASTERS) bits, minimum 1).
- Reset (rst_i=0 at a clk_i edge): gnt_valid=0, owner=0, last=MASTERS-1, so master 0 has top priority after reset; timeout counter=0.
- Reset dominates all other events, including reset in the middle of a transaction or burst: the grant drops at that edge.
- Active grant: active = gnt_valid & m_cyc_i[owner], combinational.
- Arbitration, each rising edge: if !active, search m_cyc_i from index last+1 upward with wrap-around, and pick the first requester.
  - If a requester is found: gnt_valid<=1, owner<=pick, last<=pick.
  - If none: gnt_valid<=0; last is unchanged.
- While active, requests from other masters are ignored; the grant is never preempted.
- A burst (cti=010) and a classic cycle (cti=000/111) are both held purely by cyc.
- Latency:
  - The request is registered, so the first bus cycle appears one clock after m_cyc_i rises on an idle bus.
  - When the owner drops cyc, s_cyc_o falls in the same cycle. The next owner drives the bus on the following clock, giving exactly one idle cycle at handover.
- Request muxing when active: all s_* request outputs equal the owner's slice. s_cyc_o=1 and s_stb_o=m_stb_i[owner].
- When not active: s_cyc_o=0 and s_stb_o=0. s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cti_o and s_bte_o are all 0.
- Response muxing:
  - m_ack_o, m_err_o and m_rty_o are asserted only at index owner, and only when active.
  - All other masters see 0 on these signals.
- m_dat_o: s_dat_i is broadcast to every slice; masters qualify it with their ack.
- grant_o is one-hot of owner when active, otherwise 0. Outputs are combinational from state and inputs; there is no register stage on the data path.
- Fairness: with all MASTERS requesting continuously and each dropping cyc after one transfer, grants rotate 0,1,2,...,MASTERS-1,0.
- MASTERS=1: owner is always 0; the only added behaviour is the one-cycle grant latency.

Optional Feature:
- Macro: WB_ARB_TIMEOUT_EN.
- With the macro, a 16-bit counter behaves as follows:
  - Increments each cycle when active & s_stb_o & !(s_ack_i|s_err_i|s_rty_i).
  - Clears on any response, when not active, and on reset.
  - When the count reaches TIMEOUT_CYCLES, for that one cycle: m_err_o[owner]=1, timeout_o=1, s_stb_o forced to 0. The counter then clears.
  - The grant is kept until the owner drops cyc.
- Without the macro: no counter is built, timeout_o is tied to 0, and a hung slave holds the bus indefinitely.

Test Plan:
- Reset, then master 2 asserts cyc/stb with adr 0x8000_0010 -> the next cycle has s_cyc_o=1, s_adr_o=0x8000_0010, grant_o=4'b0100. s_ack_i=1 gives m_ack_o=4'b0100.
- Masters 0 and 3 both assert cyc on the first cycle after reset -> master 0 is granted first. After master 0 drops cyc, there is one idle cycle, then master 3 is granted.
- All 4 masters request continuously with single transfers -> the grant order is 0,1,2,3,0,1 with one idle cycle between grants.
- Master 1 runs a 4-beat incrementing burst (cti 010,010,010,111) while master 0 requests -> master 1 keeps the grant for all 4 acks, and master 0 is granted only after master 1's cyc falls.
- rst_i=0 in the middle of master 1's burst -> at that edge grant_o=0 and s_cyc_o=0. After release, master 0 wins if requesting.
- With WB_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, the slave never responds -> on the 8th stalled cycle m_err_o[owner]=1 and timeout_o=1 for exactly one cycle. Without the macro, stb is held with no err.
